fabric_copy_engine: RTL

- Single-outstanding fabric master that copies LEN words from SRC to DST.
- Issues one word READ, waits for its response, then issues one word WRITE of that data and waits for its response; repeats.
- Sits upstream of fabric memory slaves (memory BFM, RAM targets). Used as a simple DMA and as a directed traffic source in fabric benches.

---
 rtl/fabric_copy_engine.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fabric_copy_engine.sv
// rtl/fabric_copy_engine.sv - single-outstanding fabric master copying LEN words from SRC to DST
package carbon_arch_pkg;
    localparam int         CARBON_FABRIC_ATTR_WIDTH_BITS = 4;
    localparam logic [7:0] CARBON_FABRIC_XACT_READ       = 8'h01;
    localparam logic [7:0] CARBON_FABRIC_XACT_WRITE      = 8'h02;
    localparam logic [7:0] CARBON_FABRIC_RESP_OK         = 8'h00;
    localparam logic [7:0] CARBON_FABRIC_RESP_SLAVE_ERR  = 8'h01;
    localparam logic [7:0] CARBON_FABRIC_RESP_DECODE_ERR = 8'h02;
endpackage

module fabric_copy_engine #(
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              ID_W    = 4,
    parameter int              OP_W    = 8,
    parameter int              SIZE_W  = 3,
    parameter int              ATTR_W  = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int              CODE_W  = 8,
    parameter int              LEN_W   = 16,
    parameter logic [ID_W-1:0] XACT_ID = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len_words,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CODE_W-1:0]   err_code,
    output logic [LEN_W-1:0]    words_done,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [OP_W-1:0]     req_op,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [ID_W-1:0]     req_id,
    output logic [SIZE_W-1:0]   req_size,
    output logic [ATTR_W-1:0]   req_attr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_wstrb,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [ID_W-1:0]     rsp_id,
    input  logic [CODE_W-1:0]   rsp_code,
    input  logic [DATA_W-1:0]   rsp_rdata
);
    localparam int                BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);
    localparam logic [OP_W-1:0]   OP_READ   = OP_W'(carbon_arch_pkg::CARBON_FABRIC_XACT_READ);
    localparam logic [OP_W-1:0]   OP_WRITE  = OP_W'(carbon_arch_pkg::CARBON_FABRIC_XACT_WRITE);
    localparam logic [CODE_W-1:0] CODE_OK   = CODE_W'(carbon_arch_pkg::CARBON_FABRIC_RESP_OK);
    localparam logic [CODE_W-1:0] CODE_BADID = {CODE_W{1'b1}};

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [LEN_W-1:0]    rem_q;
    logic [DATA_W-1:0]   data_q;
    logic                rsp_good;

    // A response is good only if it reports OK and carries our transaction ID
    assign rsp_good = (rsp_code == CODE_OK) && (rsp_id == XACT_ID);

    assign req_id   = XACT_ID;
    assign req_size = SIZE_W'($clog2(BYTES));
    assign req_attr = '0;

    // State register; reset aborts any transfer immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request/response handshake outputs
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                rsp_ready = 1'b1;
                if (start) begin
                    state_d = (len_words == '0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: begin
                busy      = 1'b1;
                req_valid = 1'b1;
                req_op    = OP_READ;
                req_addr  = src_q;
                if (req_ready) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                busy      = 1'b1;
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    state_d = rsp_good ? WR_REQ : FIN;
                end
            end
            WR_REQ: begin
                busy      = 1'b1;
                req_valid = 1'b1;
                req_op    = OP_WRITE;
                req_addr  = dst_q;
                req_wdata = data_q;
                req_wstrb = '1;
                if (req_ready) begin
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                busy      = 1'b1;
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (!rsp_good || rem_q == LEN_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latching, read-data capture, progress counting and error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            words_done <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        words_done <= '0;
                        if (len_words != '0) begin
                            src_q    <= src_addr;
                            dst_q    <= dst_addr;
                            rem_q    <= len_words;
                            err_code <= '0;
                        end
                    end
                end
                RD_RSP: begin
                    if (rsp_valid) begin
                        data_q <= rsp_rdata;
                        if (!rsp_good) begin
                            err      <= 1'b1;
                            err_code <= (rsp_code != CODE_OK) ? rsp_code : CODE_BADID;
                        end
                    end
                end
                WR_RSP: begin
                    if (rsp_valid) begin
                        if (rsp_good) begin
                            words_done <= words_done + LEN_W'(1);
                            src_q      <= src_q + STEP;
                            dst_q      <= dst_q + STEP;
                            rem_q      <= rem_q - LEN_W'(1);
                        end else begin
                            err      <= 1'b1;
                            err_code <= (rsp_code != CODE_OK) ? rsp_code : CODE_BADID;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
